multicycle_ctrl_fsm: RTL and testbench



---
 rtl/multicycle_ctrl_fsm.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control unit for the 16-bit CPU.
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK from the IR fields and drives
// the datapath enables, the memory request handshake and the ALUop input of
// ALUctrl. It also counts retired instructions and raises sticky flags for
// illegal encodings and memory timeouts.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   OPCode           IR[15:12]
//   OPCodeExtension  IR[7:4]
//   cond_true        branch condition, sampled in DECODE
//   mem_ready        memory access completes this cycle
//   ALUop, ALUsrcB   ALU class (00 RTYP, 01 ITYP, 10 SHFT) and immediate select
//   ir_write, pc_write, pc_src  IR/PC load controls (pc_src 00 PC+1, 01 disp, 10 Rsrc)
//   mem_read, mem_write, addr_sel  memory request and address select (1 = Rsrc)
//   reg_write, mem_to_reg, flag_write  write-back controls
//   illegal, fault   sticky error flags
//   retired          retired-instruction count (wraps)
module multicycle_ctrl_fsm #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       OPCode,
  input  logic [3:0]       OPCodeExtension,
  input  logic             cond_true,
  input  logic             mem_ready,
  output logic [1:0]       ALUop,
  output logic             ALUsrcB,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             addr_sel,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             flag_write,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_WB, S_MRD, S_LWB, S_MWR, S_BR, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYP, C_ITYP, C_SHFT, C_LOAD, C_STOR, C_JCOND, C_BCOND, C_HALT, C_ILL
  } cls_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic             cond_q, cond_d;

  cls_t       cls;
  logic       is_cmp;
  logic [1:0] alu_op;
  logic       retire;
  logic       mem_wait;

  // Instruction class from the IR fields; the IR is stable for the whole
  // instruction after FETCH, so this decode is valid in every later state.
  always_comb begin
    cls = C_ILL;
    unique case (OPCode)
      4'b0000: cls = C_RTYP;
      4'b1000: cls = C_SHFT;
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
      4'b0111, 4'b1001, 4'b1010, 4'b1011: cls = C_ITYP;
      4'b0100: begin
        unique case (OPCodeExtension)
          4'b0000: cls = C_LOAD;
          4'b0100: cls = C_STOR;
          4'b1100: cls = C_JCOND;
          default: cls = C_ILL;
        endcase
      end
      4'b1100: cls = C_BCOND;
      4'b1111: cls = (OPCodeExtension == 4'b1111) ? C_HALT : C_ILL;
      default: cls = C_ILL;
    endcase
    is_cmp = ((cls == C_RTYP) && (OPCodeExtension == 4'b1011)) ||
             ((cls == C_ITYP) && (OPCode == 4'b1011));
    unique case (cls)
      C_ITYP:  alu_op = 2'b01;
      C_SHFT:  alu_op = 2'b10;
      default: alu_op = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    retired_d  = retired_q;
    illegal_d  = illegal_q;
    fault_d    = fault_q;
    cond_d     = cond_q;
    retire     = 1'b0;
    mem_wait   = 1'b0;
    ALUop      = '0;
    ALUsrcB    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    flag_write = 1'b0;

    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        cond_d = cond_true;
        unique case (cls)
          C_RTYP, C_ITYP, C_SHFT: state_d = S_EXEC;
          C_LOAD:                 state_d = S_MRD;
          C_STOR:                 state_d = S_MWR;
          C_JCOND, C_BCOND:       state_d = S_BR;
          C_HALT:                 state_d = S_HALT;
          default: begin
            // Undecodable: flag it and retire as a NOP.
            illegal_d = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        ALUop   = alu_op;
        ALUsrcB = (cls == C_ITYP);
        state_d = S_WB;
      end
      S_WB: begin
        ALUop      = alu_op;
        ALUsrcB    = (cls == C_ITYP);
        flag_write = 1'b1;
        reg_write  = !is_cmp;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MRD: begin
        mem_read = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_d = S_LWB;
        else           mem_wait = 1'b1;
      end
      S_LWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MWR: begin
        mem_write = 1'b1;
        addr_sel  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_BR: begin
        pc_write = cond_q;
        pc_src   = (cls == C_BCOND) ? 2'b01 : 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase

    // wait_q is zero whenever a memory state is entered because every other
    // state (and every completed access) leaves it at its default of 0.
    // Up to MAX_WAIT stall cycles are tolerated; a further stall is a fault.
    if (mem_wait) begin
      if (wait_q == MAX_WAIT_C) begin
        fault_d = 1'b1;
        state_d = S_HALT;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end

    if (retire) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      cond_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      cond_q    <= cond_d;
    end
  end

  assign illegal = illegal_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each scenario pushes the
// expected per-cycle outputs (with the stimulus for that cycle) into a
// scoreboard queue and then drains it, comparing the DUT cycle by cycle.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [1:0] aluop;
    logic       srcb;
    logic       irw;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       mrd;
    logic       mwr;
    logic       asel;
    logic       rw;
    logic       m2r;
    logic       fw;
  } outs_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [3:0]       ext;
    logic             mr;
    logic             cond;
    outs_t            o;
    logic [CNT_W-1:0] ret;
    logic             ill;
    logic             flt;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] OPCode = '0;
  logic [3:0] OPCodeExtension = '0;
  logic cond_true = 1'b0;
  logic mem_ready = 1'b0;
  logic [1:0] ALUop;
  logic ALUsrcB, ir_write, pc_write;
  logic [1:0] pc_src;
  logic mem_read, mem_write, addr_sel, reg_write, mem_to_reg, flag_write;
  logic illegal, fault;
  logic [CNT_W-1:0] retired;

  outs_t act;
  assign act = {ALUop, ALUsrcB, ir_write, pc_write, pc_src, mem_read,
                mem_write, addr_sel, reg_write, mem_to_reg, flag_write};

  multicycle_ctrl_fsm #(.CNT_W(CNT_W), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .OPCode(OPCode), .OPCodeExtension(OPCodeExtension),
    .cond_true(cond_true), .mem_ready(mem_ready), .ALUop(ALUop), .ALUsrcB(ALUsrcB),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
    .mem_write(mem_write), .addr_sel(addr_sel), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .flag_write(flag_write), .illegal(illegal),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  entry_t sb[$];
  entry_t e;
  logic [CNT_W-1:0] model_ret = '0;
  logic model_ill = 1'b0;
  logic model_flt = 1'b0;
  logic [3:0] cur_op = '0;
  logic [3:0] cur_ext = '0;

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // ---------------- scoreboard stimulus builders ----------------
  task automatic push(input outs_t o, input logic mr, input logic c, input bit ret);
    entry_t x;
    x.op = cur_op; x.ext = cur_ext; x.mr = mr; x.cond = c; x.o = o;
    x.ret = model_ret; x.ill = model_ill; x.flt = model_flt;
    sb.push_back(x);
    if (ret) model_ret = model_ret + 1'b1;
  endtask

  task automatic set_ir(input logic [3:0] op, input logic [3:0] ext);
    cur_op = op; cur_ext = ext;
  endtask

  task automatic push_fetch(input int unsigned waits);
    outs_t o;
    o = '0; o.mrd = 1'b1;
    for (int unsigned i = 0; i < waits; i++) push(o, 1'b0, rnd(), 1'b0);
    o.irw = 1'b1; o.pcw = 1'b1;
    push(o, 1'b1, rnd(), 1'b0);
  endtask

  task automatic push_decode(input logic c, input bit ret);
    push('0, rnd(), c, ret);
  endtask

  task automatic push_alu(input logic [1:0] op, input logic srcb, input logic rw);
    outs_t o;
    o = '0; o.aluop = op; o.srcb = srcb;
    push(o, rnd(), rnd(), 1'b0);
    o.fw = 1'b1; o.rw = rw;
    push(o, rnd(), rnd(), 1'b1);
  endtask

  task automatic push_rst_cycle();
    model_ret = '0; model_ill = 1'b0; model_flt = 1'b0;
    push('0, rnd(), rnd(), 1'b0);
  endtask

  // Holds reset across one edge; the S_RST cycle that follows is queued.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = rnd();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_rst_cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({act, retired, illegal, fault} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got outs=%h ret=%h ill=%b flt=%b, want all zero",
               act, retired, illegal, fault);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_rst_cycle();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      OPCode = e.op; OPCodeExtension = e.ext; mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL reset_exit: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    set_ir(4'b0000, 4'b0101); push_fetch(0); push_decode(rnd(), 0); push_alu(2'b00, 1'b0, 1'b1);
    set_ir(4'b1011, 4'b0011); push_fetch(2); push_decode(rnd(), 0); push_alu(2'b01, 1'b1, 1'b0);
    set_ir(4'b1000, 4'b0110); push_fetch(0); push_decode(rnd(), 0); push_alu(2'b10, 1'b0, 1'b1);
    set_ir(4'b0000, 4'b1011); push_fetch(1); push_decode(rnd(), 0); push_alu(2'b00, 1'b0, 1'b0);
    set_ir(4'b0101, 4'b1011); push_fetch(0); push_decode(rnd(), 0); push_alu(2'b01, 1'b1, 1'b1);
    set_ir(4'b1010, 4'b0000); push_fetch(0); push_decode(rnd(), 0); push_alu(2'b01, 1'b1, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      OPCode = e.op; OPCodeExtension = e.ext; mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL alu op=%b ext=%b: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 e.op, e.ext, act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    outs_t o;
    int unsigned waits[2] = '{3, 15};
    for (int k = 0; k < 2; k++) begin
      set_ir(4'b0100, 4'b0000);
      push_fetch(waits[k]);
      push_decode(rnd(), 0);
      o = '0; o.mrd = 1'b1; o.asel = 1'b1;
      for (int unsigned i = 0; i < waits[k]; i++) push(o, 1'b0, rnd(), 1'b0);
      push(o, 1'b1, rnd(), 1'b0);
      o = '0; o.rw = 1'b1; o.m2r = 1'b1;
      push(o, rnd(), rnd(), 1'b1);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      OPCode = e.op; OPCodeExtension = e.ext; mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL load: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_store();
    outs_t o;
    // STOR, no wait then two waits
    for (int unsigned w = 0; w < 3; w += 2) begin
      set_ir(4'b0100, 4'b0100); push_fetch(0); push_decode(rnd(), 0);
      o = '0; o.mwr = 1'b1; o.asel = 1'b1;
      for (int unsigned i = 0; i < w; i++) push(o, 1'b0, rnd(), 1'b0);
      push(o, 1'b1, rnd(), 1'b1);
    end
    // BCOND taken / not taken; cond_true flips in S_BR to expose a non-registered path
    for (int c = 1; c >= 0; c--) begin
      set_ir(4'b1100, 4'b0010); push_fetch(0); push_decode(1'(c), 0);
      o = '0; o.pcw = 1'(c); o.pcsrc = 2'b01;
      push(o, rnd(), ~1'(c), 1'b1);
    end
    // JCOND taken
    set_ir(4'b0100, 4'b1100); push_fetch(0); push_decode(1'b1, 0);
    o = '0; o.pcw = 1'b1; o.pcsrc = 2'b10;
    push(o, rnd(), 1'b0, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      OPCode = e.op; OPCodeExtension = e.ext; mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL br_stor op=%b ext=%b: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 e.op, e.ext, act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_halt();
    logic [7:0] ill_enc[3] = '{8'hD0, 8'h41, 8'hF0};
    for (int k = 0; k < 3; k++) begin
      set_ir(ill_enc[k][7:4], ill_enc[k][3:0]);
      push_fetch(0); push_decode(rnd(), 1);
      model_ill = 1'b1;
    end
    // HALT is not retired; FSM stays halted while mem_ready toggles
    set_ir(4'b1111, 4'b1111); push_fetch(0); push_decode(rnd(), 0);
    for (int i = 0; i < 4; i++) push('0, rnd(), rnd(), 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      OPCode = e.op; OPCodeExtension = e.ext; mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL ill_halt op=%b ext=%b: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 e.op, e.ext, act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
    do_reset();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL halt_reset: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fault();
    outs_t o;
    set_ir(4'b0000, 4'b0101);
    o = '0; o.mrd = 1'b1;
    // 15 tolerated stalls plus the stall that trips the timeout
    for (int i = 0; i < 16; i++) push(o, 1'b0, rnd(), 1'b0);
    model_flt = 1'b1;
    for (int i = 0; i < 5; i++) push('0, rnd(), rnd(), 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      OPCode = e.op; OPCodeExtension = e.ext; mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL fault: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
    do_reset();
    while (sb.size() != 0) begin
      e = sb.pop_front();
      mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL fault_reset: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    set_ir(4'b1101, 4'b0000);
    while (model_ret != '1) begin
      push_fetch(0); push_decode(rnd(), 1);
      model_ill = 1'b1;
    end
    set_ir(4'b0000, 4'b0001); push_fetch(0); push_decode(rnd(), 0); push_alu(2'b00, 1'b0, 1'b1);
    set_ir(4'b1101, 4'b0000); push_fetch(0); push_decode(rnd(), 1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      OPCode = e.op; OPCodeExtension = e.ext; mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL wrap: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_store();
    outs_t o;
    set_ir(4'b0100, 4'b0100); push_fetch(0); push_decode(rnd(), 0);
    o = '0; o.mwr = 1'b1; o.asel = 1'b1;
    push(o, 1'b0, rnd(), 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      OPCode = e.op; OPCodeExtension = e.ext; mem_ready = e.mr; cond_true = e.cond;
      @(negedge clk);
      n_chk++;
      if ({act, retired, illegal, fault} !== {e.o, e.ret, e.ill, e.flt}) begin
        n_fail++;
        $display("FAIL mid_store: got outs=%h ret=%h ill=%b flt=%b, want outs=%h ret=%h ill=%b flt=%b",
                 act, retired, illegal, fault, e.o, e.ret, e.ill, e.flt);
      end
      @(posedge clk); #1;
    end
    // Still waiting in S_MWR; reset arrives together with mem_ready.
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (act !== o) begin
      n_fail++;
      $display("FAIL mid_store_req: got outs=%h, want outs=%h", act, o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({act, retired, illegal, fault} !== '0) begin
      n_fail++;
      $display("FAIL mid_store_abort: got outs=%h ret=%h ill=%b flt=%b, want all zero",
               act, retired, illegal, fault);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch_store();
    test_illegal_halt();
    test_fault();
    test_wrap();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
